// File: rtl/msg_schedule.sv
// -----------------------------------------------------------------------------
// msg_schedule -- SHA-256 message-schedule expander.
//
// Accepts one 512-bit block as 16 serial 32-bit words (W0 first) and emits the
// 64 schedule words W0..W63 in order, one per output handshake. W0..W15 are
// echoed as they are loaded; W16..W63 are expanded from a 16-word sliding
// window:
//   Wt = sigma1(W(t-2)) + W(t-7) + sigma0(W(t-15)) + W(t-16)   (mod 2^32)
// All words use [0:31] with bit 0 as the MSB.
//
// Optional feature macro: MSG_SCHED_STALL_EN
//   defined   : W_READY port exists; outputs hold while W_VALID && !W_READY,
//               loading and expansion freeze, IN_READY drops.
//   undefined : no W_READY port; consumer accepts every W_VALID pulse.
//
// Ports:
//   CLK       in   system clock, rising edge
//   RST_N     in   asynchronous active-low reset
//   CLR       in   synchronous clear, abandons the current block
//   IN_VALID  in   IN_WORD valid
//   IN_READY  out  a word is accepted this cycle when IN_VALID is high
//   IN_WORD   in   [0:31] message word, W0 first
//   W_VALID   out  W_OUT / W_IDX valid
//   W_OUT     out  [0:31] schedule word Wt (registered)
//   W_IDX     out  [0:5]  index t of W_OUT
//   W_LAST    out  high with W_VALID when W_IDX = 63
//   W_READY   in   consumer accepts (MSG_SCHED_STALL_EN only)
// -----------------------------------------------------------------------------

// Small sigma0: ROTR7 ^ ROTR18 ^ SHR3 on an MSB-first word.
module sigma0 (
    input  logic [0:31] x,
    output logic [0:31] y
);
    // With bit 0 as MSB, rotating right by n moves the n low-order bits
    // x[32-n:31] to the top of the word.
    assign y = {x[25:31], x[0:24]}
             ^ {x[14:31], x[0:13]}
             ^ {3'b000,   x[0:28]};
endmodule

// Small sigma1 (MOD_S1): ROTR17 ^ ROTR19 ^ SHR10 on an MSB-first word.
module mod_s1 (
    input  logic [0:31] x,
    output logic [0:31] y
);
    assign y = {x[15:31], x[0:14]}
             ^ {x[13:31], x[0:12]}
             ^ {10'b0,    x[0:21]};
endmodule

module msg_schedule #(
    parameter int WORDS_IN = 16,
    parameter int ROUNDS   = 64
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        CLR,
    input  logic        IN_VALID,
    output logic        IN_READY,
    input  logic [0:31] IN_WORD,
    output logic        W_VALID,
    output logic [0:31] W_OUT,
    output logic [0:5]  W_IDX,
    output logic        W_LAST
`ifdef MSG_SCHED_STALL_EN
    ,
    input  logic        W_READY
`endif
);

    typedef enum logic {
        ST_LOAD   = 1'b0,
        ST_EXPAND = 1'b1
    } state_t;

    localparam logic [0:5] LAST_LOAD  = 6'(WORDS_IN - 1);
    localparam logic [0:5] LAST_ROUND = 6'(ROUNDS - 1);

    state_t      state_q;
    state_t      state_d;
    logic [0:5]  count_q;
    logic [0:31] win_q [16];   // [0] = W(t-16) oldest ... [15] = W(t-1) newest

    logic        w_valid_q;
    logic [0:31] w_out_q;
    logic [0:5]  w_idx_q;
    logic        w_last_q;

    logic        take;
    logic        load_fire;
    logic        exp_fire;
    logic        produce;
    logic [0:31] s1_out;
    logic [0:31] s0_out;
    logic [0:31] wt;
    logic [0:31] new_word;

    // -------------------------------------------------------------------------
    // Output-side acceptance: the held word is gone (or will be gone at this
    // edge), so a new word may be produced.
    // -------------------------------------------------------------------------
`ifdef MSG_SCHED_STALL_EN
    assign take = !w_valid_q || W_READY;
`else
    assign take = 1'b1;
`endif

    // -------------------------------------------------------------------------
    // Expansion datapath
    // -------------------------------------------------------------------------
    mod_s1 u_s1 (
        .x (win_q[14]),
        .y (s1_out)
    );

    sigma0 u_s0 (
        .x (win_q[1]),
        .y (s0_out)
    );

    // Carries beyond bit 0 fall off the 32-bit result: addition is mod 2^32.
    assign wt = s1_out + win_q[9] + s0_out + win_q[0];

    assign load_fire = (state_q == ST_LOAD) && IN_VALID && IN_READY;
    assign exp_fire  = (state_q == ST_EXPAND) && take;
    assign produce   = load_fire || exp_fire;
    assign new_word  = (state_q == ST_LOAD) ? IN_WORD : wt;

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    // NOTE: assigning a default before any branch keeps combinational blocks
    // from inferring latches on paths that do not write the variable.
    always_comb begin
        state_d = state_q;
        if (CLR) begin
            state_d = ST_LOAD;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    if (load_fire && (count_q == LAST_LOAD)) begin
                        state_d = ST_EXPAND;
                    end
                end
                ST_EXPAND: begin
                    if (exp_fire && (count_q == LAST_ROUND)) begin
                        state_d = ST_LOAD;
                    end
                end
                default: state_d = ST_LOAD;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // FSM: outputs
    // -------------------------------------------------------------------------
    // Without the stall feature take is constant 1, so this is simply
    // "ready while loading".
    always_comb begin
        IN_READY = 1'b0;
        if (state_q == ST_LOAD) begin
            IN_READY = take;
        end
    end

    // -------------------------------------------------------------------------
    // Sliding window. Every loaded or expanded word enters at win[15].
    // -------------------------------------------------------------------------
    // NOTE: the window is a register array rather than a RAM, so it can take
    // the asynchronous reset; CLR leaves it alone because all 16 entries are
    // rewritten by the next load before expansion reads any of them.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < 16; i++) begin
                win_q[i] <= '0;
            end
        end else if (!CLR && produce) begin
            for (int i = 0; i < 15; i++) begin
                win_q[i] <= win_q[i + 1];
            end
            win_q[15] <= new_word;
        end
    end

    // -------------------------------------------------------------------------
    // Word counter and registered output stage
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            count_q   <= '0;
            w_valid_q <= 1'b0;
            w_out_q   <= '0;
            w_idx_q   <= '0;
            w_last_q  <= 1'b0;
        end else if (CLR) begin
            // Clear wins over any handshake in the same cycle.
            count_q   <= '0;
            w_valid_q <= 1'b0;
            w_out_q   <= '0;
            w_idx_q   <= '0;
            w_last_q  <= 1'b0;
        end else if (produce) begin
            // count wraps 63 -> 0, which is exactly the next block's W0.
            count_q   <= count_q + 6'd1;
            w_valid_q <= 1'b1;
            w_out_q   <= new_word;
            w_idx_q   <= count_q;
            w_last_q  <= (count_q == LAST_ROUND);
        end else if (take) begin
            // Held word consumed and nothing new: drop valid, keep data.
            w_valid_q <= 1'b0;
            w_last_q  <= 1'b0;
        end
    end

    assign W_VALID = w_valid_q;
    assign W_OUT   = w_out_q;
    assign W_IDX   = w_idx_q;
    assign W_LAST  = w_last_q;

    // -------------------------------------------------------------------------
    // Assertions
    // -------------------------------------------------------------------------
    a_load_count : assert property (@(posedge CLK) disable iff (!RST_N)
        (state_q == ST_LOAD) |-> (count_q <= LAST_LOAD));

    a_last_valid : assert property (@(posedge CLK) disable iff (!RST_N)
        W_LAST |-> W_VALID);

endmodule

// File: tb/tb_msg_schedule.sv
// -----------------------------------------------------------------------------
// tb_msg_schedule -- self-checking bench for msg_schedule.
// A reference model computes the full 64-word schedule of each block with
// plain arithmetic; a negedge monitor compares every consumed output word
// against a queue of expected words. Directed cases cover the "abc" vector,
// the all-zero block, back-to-back blocks, async reset mid-block, CLR in
// LOAD and (with MSG_SCHED_STALL_EN) an output stall.
// -----------------------------------------------------------------------------
module tb_msg_schedule;

    logic        CLK      = 1'b0;
    logic        RST_N    = 1'b1;
    logic        CLR      = 1'b0;
    logic        IN_VALID = 1'b0;
    logic        IN_READY;
    logic [0:31] IN_WORD  = '0;
    logic        W_VALID;
    logic [0:31] W_OUT;
    logic [0:5]  W_IDX;
    logic        W_LAST;
`ifdef MSG_SCHED_STALL_EN
    logic        W_READY  = 1'b1;
    int          rdy_mode = 0;   // 0: always ready, 1: random, 2: driven by main
`endif

    msg_schedule dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .CLR      (CLR),
        .IN_VALID (IN_VALID),
        .IN_READY (IN_READY),
        .IN_WORD  (IN_WORD),
        .W_VALID  (W_VALID),
        .W_OUT    (W_OUT),
        .W_IDX    (W_IDX),
        .W_LAST   (W_LAST)
`ifdef MSG_SCHED_STALL_EN
        ,
        .W_READY  (W_READY)
`endif
    );

    always #5 CLK = ~CLK;

    // ------------------------------------------------------------------ checks
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ----------------------------------------------------------- reference model
    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    typedef struct {
        int          idx;
        logic [31:0] word;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] blk   [16];
    logic [31:0] ref_w [64];

    // Full schedule of the current blk, appended to the expected stream.
    task automatic push_expected();
        exp_t e;
        for (int t = 0; t < 64; t++) begin
            if (t < 16) ref_w[t] = blk[t];
            else        ref_w[t] = ssig1(ref_w[t-2]) + ref_w[t-7] + ssig0(ref_w[t-15]) + ref_w[t-16];
            e.idx  = t;
            e.word = ref_w[t];
            exp_q.push_back(e);
        end
    endtask

    task automatic set_abc();
        for (int i = 0; i < 16; i++) blk[i] = 32'h0;
        blk[0]  = 32'h61626380;
        blk[15] = 32'h00000018;
    endtask

    // ----------------------------------------------------------------- monitor
    bit          mon_en = 1'b0;
    int          cyc = 0;
    logic [31:0] obs_w [64];
    int          last_cnt  = 0;
    int          cyc_first = 0;
    int          cyc_last  = 0;
`ifdef MSG_SCHED_STALL_EN
    bit          prev_stall = 1'b0;
    logic [31:0] prev_out;
    logic [5:0]  prev_idx;
`endif

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin : mon
        bit   wrdy;
        exp_t e;
`ifdef MSG_SCHED_STALL_EN
        wrdy = W_READY;
`else
        wrdy = 1'b1;
`endif
        if (mon_en) begin
            if (!W_VALID) check("w_last_idle", W_LAST, 0);
`ifdef MSG_SCHED_STALL_EN
            if (prev_stall) begin
                check("hold_valid", W_VALID, 1);
                check("hold_out", W_OUT, prev_out);
                check("hold_idx", W_IDX, prev_idx);
            end
            if (W_VALID && !W_READY) check("stall_in_ready", IN_READY, 0);
            prev_stall = W_VALID && !W_READY;
            prev_out   = W_OUT;
            prev_idx   = W_IDX;
`endif
            if (W_VALID && wrdy) begin
                if (exp_q.size() == 0) begin
                    check("spurious_w_valid", W_VALID, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("w_idx", W_IDX, e.idx);
                    check("w_out", W_OUT, e.word);
                    check("w_last", W_LAST, e.idx == 63);
                    obs_w[W_IDX] = W_OUT;
                    if (W_LAST) last_cnt++;
                    if (e.idx == 0)  cyc_first = cyc;
                    if (e.idx == 63) cyc_last  = cyc;
                end
            end
        end else begin
`ifdef MSG_SCHED_STALL_EN
            prev_stall = 1'b0;
`endif
        end
    end

`ifdef MSG_SCHED_STALL_EN
    always @(posedge CLK) begin
        #1;
        if (rdy_mode == 0)      W_READY = 1'b1;
        else if (rdy_mode == 1) W_READY = ($urandom_range(0, 3) != 0);
    end
`endif

    // ---------------------------------------------------------------- stimulus
    // All stimulus tasks start and end 1 time unit after a rising edge.
    bit         last_hs_wvalid;
    logic [5:0] last_hs_widx;
    bit         blk_hs_wvalid;
    logic [5:0] blk_hs_widx;
    bit         first_valid_after;
    logic [5:0] first_idx_after;

    task automatic send_word(input logic [31:0] w, input bit gap);
        bit done = 1'b0;
        if (gap) begin
            IN_VALID = 1'b0;
            repeat ($urandom_range(0, 2)) begin
                @(posedge CLK); #1;
            end
        end
        IN_VALID = 1'b1;
        IN_WORD  = w;
        for (int n = 0; n < 400 && !done; n++) begin
            @(negedge CLK);
            if (IN_READY) begin
                done           = 1'b1;
                last_hs_wvalid = W_VALID;
                last_hs_widx   = W_IDX;
            end
            @(posedge CLK); #1;
        end
        if (!done) check("in_ready_timeout", IN_READY, 1);
    endtask

    task automatic feed_block(input bit gap);
        push_expected();
        for (int i = 0; i < 16; i++) begin
            send_word(blk[i], gap);
            if (i == 0) begin
                blk_hs_wvalid     = last_hs_wvalid;
                blk_hs_widx       = last_hs_widx;
                first_valid_after = W_VALID;
                first_idx_after   = W_IDX;
            end
        end
        IN_VALID = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 3000 && exp_q.size() != 0; n++) begin
            @(posedge CLK); #1;
        end
        check("drain_left", exp_q.size(), 0);
    endtask

    task automatic wait_idx(input int idx);
        bit found = 1'b0;
        for (int n = 0; n < 200 && !found; n++) begin
            @(posedge CLK); #1;
            if (W_VALID && W_IDX == 6'(idx)) found = 1'b1;
        end
        check("reach_idx", W_IDX, idx);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        // ---------------- reset state
        #1 RST_N = 1'b0;
        #1;
        check("rst_w_valid", W_VALID, 0);
        check("rst_w_out", W_OUT, 0);
        check("rst_w_idx", W_IDX, 0);
        check("rst_w_last", W_LAST, 0);
        repeat (2) @(posedge CLK);
        @(negedge CLK) RST_N = 1'b1;
        @(posedge CLK); #1;
        check("rst_in_ready", IN_READY, 1);

        // ---------------- "abc" block
        mon_en   = 1'b1;
        last_cnt = 0;
        for (int i = 0; i < 64; i++) obs_w[i] = '0;
        set_abc();
        feed_block(1'b0);
        drain();
        check("abc_w16", obs_w[16], 32'h61626380);
        check("abc_w17", obs_w[17], 32'h000F0000);
        check("abc_w63", obs_w[63], 32'h12B1EDEB);
        check("abc_last_count", last_cnt, 1);
        repeat (2) @(posedge CLK); #1;

        // ---------------- all-zero block, timing
        for (int i = 0; i < 16; i++) blk[i] = 32'h0;
        feed_block(1'b0);
        check("zero_first_valid", first_valid_after, 1);
        check("zero_first_idx", first_idx_after, 0);
        drain();
        check("zero_span_cycles", cyc_last - cyc_first, 63);
        repeat (2) @(posedge CLK); #1;

        // ---------------- back-to-back blocks
        set_abc();
        feed_block(1'b0);
        feed_block(1'b0);
        check("b2b_w0_with_w63_valid", blk_hs_wvalid, 1);
        check("b2b_w0_with_w63_idx", blk_hs_widx, 63);
        drain();
        repeat (2) @(posedge CLK); #1;

        // ---------------- async reset mid-block
        set_abc();
        feed_block(1'b0);
        wait_idx(20);
        mon_en = 1'b0;
        #2 RST_N = 1'b0;
        #1;
        check("arst_w_valid", W_VALID, 0);
        check("arst_w_out", W_OUT, 0);
        check("arst_w_idx", W_IDX, 0);
        check("arst_w_last", W_LAST, 0);
        @(posedge CLK); #1 RST_N = 1'b1;
        exp_q.delete();
        mon_en = 1'b1;
        feed_block(1'b0);
        drain();
        repeat (2) @(posedge CLK); #1;

        // ---------------- CLR in LOAD at count 5
        mon_en = 1'b0;
        for (int i = 0; i < 16; i++) blk[i] = $urandom;
        for (int i = 0; i < 5; i++) send_word(blk[i], 1'b0);
        IN_WORD  = 32'hDEADBEEF;
        IN_VALID = 1'b1;
        CLR      = 1'b1;
        @(posedge CLK); #1;
        CLR      = 1'b0;
        IN_VALID = 1'b0;
        check("clr_w_valid", W_VALID, 0);
        check("clr_w_idx", W_IDX, 0);
        check("clr_w_out", W_OUT, 0);
        check("clr_in_ready", IN_READY, 1);
        mon_en = 1'b1;
        set_abc();
        feed_block(1'b0);
        drain();
        repeat (2) @(posedge CLK); #1;

`ifdef MSG_SCHED_STALL_EN
        // ---------------- output stall at W17
        rdy_mode = 2;
        W_READY  = 1'b1;
        set_abc();
        feed_block(1'b0);
        wait_idx(17);
        W_READY = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            check("stall_w_out", W_OUT, 32'h000F0000);
            check("stall_w_idx", W_IDX, 17);
            check("stall_in_ready_low", IN_READY, 0);
            @(posedge CLK); #1;
        end
        W_READY = 1'b1;
        @(posedge CLK); #1;
        check("stall_next_idx", W_IDX, 18);
        check("stall_next_out", W_OUT, ref_w[18]);
        drain();
        check("stall_w63", obs_w[63], 32'h12B1EDEB);
        repeat (2) @(posedge CLK); #1;
        rdy_mode = 1;
`endif

        // ---------------- random blocks, random input gaps
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 16; i++) blk[i] = $urandom;
            feed_block(r[0]);
            if (r % 3 == 2) drain();
        end
        drain();
        repeat (3) @(posedge CLK); #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/msg_schedule.md
Name: msg_schedule

Overview:
- SHA-256 message-schedule expander. It accepts one 512-bit block as 16 serial 32-bit words and emits the 64 schedule words W0..W63 in order, one per handshake.
- Sits between the block/padding front end and the compression round engine.
- Instantiates the existing MOD_S1 (sigma1) block and the existing sigma0 block (ROTR7 ^ ROTR18 ^ SHR3).
- All words are [0:31] with bit 0 as MSB, matching the sigma blocks.

Parameters:
- WORDS_IN, 16, number of block words loaded before expansion. Fixed at 16 by the algorithm; exposed only for assertions.
- ROUNDS, 64, number of schedule words emitted per block.

Ports:
- CLK  input  1  system clock, rising edge.
- RST_N  input  1  reset, asynchronous assert, active-low.
- CLR  input  1  synchronous clear; abandons the current block.
- IN_VALID  input  1  IN_WORD valid.
- IN_READY  output  1  block accepts a word this cycle.
- IN_WORD  input  [0:31]  message word, W0 first.
- W_VALID  output  1  W_OUT/W_IDX valid.
- W_OUT  output  [0:31]  schedule word Wt, registered.
- W_IDX  output  [0:5]  t of W_OUT (0..63).
- W_LAST  output  1  high with W_VALID when W_IDX = 63.
- W_READY  input  1  consumer accepts; present only with MSG_SCHED_STALL_EN.

Behaviour:
- Reset (RST_N=0, async): state LOAD; count 0; 16-word window cleared; W_VALID=0, W_OUT=0, W_IDX=0, W_LAST=0. IN_READY=1 after reset release.
- Window win[0..15]: win[0] holds W(t-16) (oldest), win[15] holds W(t-1) (newest). Every accepted or computed word shifts in at win[15].
- `take` = !W_VALID || W_READY. Without the macro, W_READY is treated as 1.
- State LOAD:
  - IN_READY = take.
  - On IN_VALID && IN_READY: shift IN_WORD into the window. Next cycle: W_OUT = IN_WORD, W_IDX = count, W_VALID = 1. Then count++.
  - After word 15 is accepted, go to EXPAND with count = 16.
- State EXPAND:
  - IN_READY = 0.
  - When take: Wt = MOD_S1(win[14]) + win[9] + sigma0(win[1]) + win[0], modulo 2^32, carries discarded. Shift Wt into the window; register it to W_OUT with W_IDX = count and W_VALID = 1; count++.
  - When count = 63 is produced: W_LAST = 1 with it, then return to LOAD with count = 0.
  - Latency: 1 cycle from acceptance/compute to W_VALID. Throughput: one word per cycle when unstalled.
- W_VALID clears on the next clock edge when nothing new is produced and the held word has been taken. Without the macro, W_VALID is therefore a 1-cycle pulse per word.
- Block boundary: the first word of the next block may be accepted in the same cycle W63 is taken. There is no bubble between blocks.
- CLR (synchronous):
  - Same result as reset, except the window is not required to clear.
  - CLR has priority over any simultaneous IN or W handshake. A word offered in the CLR cycle is dropped.
- IN_VALID while IN_READY=0: ignored, no state change.
- Reset mid-block: the partial block is discarded. The next accepted word is treated as W0.

Optional Feature:
- Macro MSG_SCHED_STALL_EN.
- Defined:
  - The W_READY port exists.
  - W_OUT, W_IDX and W_LAST hold stable while W_VALID=1 && W_READY=0.
  - Expansion and loading freeze while stalled; IN_READY drops.
- Undefined:
  - No W_READY port; the consumer must accept every W_VALID pulse.
  - IN_READY = (state == LOAD).

Test Plan:
- "abc" block (W0=0x61626380, W1..W14=0, W15=0x00000018) fed on consecutive cycles -> 64 words with W_IDX 0..63 in order; W16=0x61626380, W17=0x000F0000, W63=0x12B1EDEB with W_LAST=1; no other W_LAST.
- All-zero block -> W0..W63 all 0x00000000; first W_VALID exactly 1 cycle after the first IN handshake; the 64 words span 64 consecutive cycles.
- Two back-to-back "abc" blocks with IN_VALID held high -> second block's W0 accepted the same cycle W63 is emitted; second stream identical to the first.
- RST_N low for 1 cycle after W20 -> all outputs 0 immediately (async); the next block restarts at W_IDX=0 and produces the correct "abc" schedule.
- CLR asserted together with IN_VALID in LOAD at count=5 -> that word is dropped, count=0, W_VALID=0 next cycle.
- (MSG_SCHED_STALL_EN) W_READY held low 3 cycles at W_IDX=17 -> W_OUT stays 0x000F0000 and IN_READY=0 throughout; W18 follows the cycle after W_READY rises; final W63 is unchanged.
